imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, flow-controlled immediate-decode stage between fetch and execute. Accepts one 32-bit RV instruction plus PC per cycle over a valid/ready handshake, reconstructs the sign- or zero-extended immediate for every base format at XLEN width, classifies the format, flags illegal opcodes, and forwards everything with one cycle of latency. A two-entry output/skid buffer sustains full throughput under back-pressure and supports a pipeline flush.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64. Immediates are sign-extended to XLEN.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept an input entry.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address, passed through.
- out_valid  out  1  output entry present.
- out_ready  in  1  consumer accepts the output entry.
- out_instr  out  32  forwarded instruction.
- out_pc  out  XLEN  forwarded PC.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_illegal  out  1  opcode is not recognised.

## Operation
- Decode uses opcode bits [6:0]:
  - I-format (fmt 1), imm = sext(instr[31:20]): 0000011, 0010011, 1100111, 0001111, 1110011.
  - S-format (fmt 2), imm = sext({[31:25],[11:7]}): 0100011.
  - B-format (fmt 3), imm = sext({[31],[7],[30:25],[11:8],0}): 1100011.
  - U-format (fmt 4), imm = sext({[31:12],12'b0}): 0110111, 0010111. With XLEN=64, bit 31 extends into the upper word.
  - J-format (fmt 5), imm = sext({[31],[19:12],[20],[30:21],0}): 1101111.
  - R-type 0110011: fmt 0, imm 0, not illegal.
- Any other opcode, including any word with [1:0] ≠ 11: fmt 0, imm 0, out_illegal = 1.
- Decode is combinational on in_instr. The result is captured together with instr and pc.
- Storage:
  - Output register (OR) drives the out_* ports.
  - Skid register (SR) holds one extra entry.
  - in_ready = !SR.valid.
- Input accept when in_valid && in_ready:
  - OR empty, or OR being consumed this cycle → the entry loads OR.
  - Otherwise → the entry loads SR.
- Output consume when out_valid && out_ready:
  - SR holds an entry → SR moves to OR and SR empties.
  - Simultaneous accept with SR empty → the new entry goes straight to OR.
- Order is strictly preserved. No entry is dropped or duplicated.
- flush clears OR.valid and SR.valid on the next edge. It has priority over a simultaneous accept: the entry is accepted and discarded.

## Timing
- Reset values: out_valid 0, out_instr 0, out_pc 0, out_imm 0, out_fmt 0, out_illegal 0, SR empty, in_ready 1.
- Latency: an entry accepted at edge N is visible on out_* after edge N.
- Throughput: one entry per cycle while out_ready = 1.
- in_ready is a registered state signal. It does not depend combinationally on out_ready.
- With out_ready held low, at most two entries are absorbed. in_ready falls after the second accept.
- out_* hold stable while out_valid && !out_ready.
- rst asserted mid-stream empties both registers immediately, without waiting for a clock edge.

## Configuration
- CSR_IMM_EN defined:
  - Opcode 1110011 with funct3[2] = 1 (csrrwi, csrrsi, csrrci) decodes as fmt 6 (Z).
  - imm = zero-extended instr[19:15].
- CSR_IMM_EN undefined: all 1110011 words decode as I-format. fmt 6 is never produced.

## Structure
- Shared package holds:
  - Opcode constants.
  - The 3-bit format enum.
  - The XLEN-parametrised sign-extension function.
- Sub-module imm_decode_comb: the purely combinational instr → {imm, fmt, illegal} decoder. The parent holds OR, SR and the handshake logic.

## Test plan
- Decode check, XLEN=32, each instruction streamed in with out_ready = 1:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, fmt 1.
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, fmt 3.
  - 0x12345137 (lui) → imm 0x12345000, fmt 4.
- XLEN=64: 0x80000037 (lui) → imm 0xFFFFFFFF80000000, fmt 4. 0x00000033 → fmt 0, illegal 0. 0x0000007F → illegal 1, imm 0.
- Back-pressure: stream 6 distinct entries with out_ready low for cycles 2–4 → in_ready drops after two entries are buffered. All 6 emerge in order with no loss or duplication.
- Flush: flush with OR and SR full and in_valid = 1 → out_valid 0 next cycle, in_ready 1. None of the three entries ever appears.
- 0x300FD073 (csrrwi x0, 0x300, 31): with CSR_IMM_EN → fmt 6, imm 0x1F. Without → fmt 1, imm 0x300.
- Assert rst between edges while both registers are full → out_valid falls immediately, all outputs go to 0, in_ready goes to 1.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared opcode constants, format enum, decode payload and XLEN sign-extension helper
// for the immediate-decode stage.
package imm_decode_stage_pkg;

    localparam int unsigned ILEN     = 32;
    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned FMT_W    = 3;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // Immediate is kept at 32 bits (all base immediates fit) and widened at the output.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

    // Widen a 32-bit signed immediate to XLEN; callers truncate to their own XLEN.
    function automatic logic [MAX_XLEN-1:0] sext_xlen(input logic [ILEN-1:0] v,
                                                      input int unsigned xlen);
        if (xlen > ILEN) begin
            return {{(MAX_XLEN-ILEN){v[ILEN-1]}}, v};
        end
        return {{(MAX_XLEN-ILEN){1'b0}}, v};
    endfunction

endpackage

// File: rtl/imm_decode_stage_comb.sv
// Combinational RV instruction -> {immediate, format, illegal} decoder.
// Optional CSR_IMM_EN: csrrwi/csrrsi/csrrci decode as Z-format with zero-extended rs1 field.
module imm_decode_comb
    import imm_decode_stage_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    output logic [ILEN-1:0] imm_c,
    output fmt_e            fmt_c,
    output logic            illegal_c
);

    always_comb begin
        imm_c     = '0;
        fmt_c     = FMT_NONE;
        illegal_c = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_OP_IMM, OP_JALR, OP_MISC_MEM: begin
                imm_c = {{20{instr[31]}}, instr[31:20]};
                fmt_c = FMT_I;
            end
            OP_SYSTEM: begin
`ifdef CSR_IMM_EN
                if (instr[14]) begin
                    imm_c = {27'b0, instr[19:15]};
                    fmt_c = FMT_Z;
                end else begin
                    imm_c = {{20{instr[31]}}, instr[31:20]};
                    fmt_c = FMT_I;
                end
`else
                imm_c = {{20{instr[31]}}, instr[31:20]};
                fmt_c = FMT_I;
`endif
            end
            OP_STORE: begin
                imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_c = FMT_S;
            end
            OP_BRANCH: begin
                imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt_c = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm_c = {instr[31:12], 12'b0};
                fmt_c = FMT_U;
            end
            OP_JAL: begin
                imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt_c = FMT_J;
            end
            OP_OP: begin
                fmt_c = FMT_NONE;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a two-entry output/skid buffer and flush.
// Optional feature macro: CSR_IMM_EN (Z-format CSR immediates, handled in the decoder).
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal
);

    logic [ILEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    dec_t            new_entry;

    imm_decode_comb u_dec (
        .instr     (in_instr),
        .imm_c     (dec_imm),
        .fmt_c     (dec_fmt),
        .illegal_c (dec_illegal)
    );

    assign new_entry = '{instr: in_instr, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    dec_t            or_q, or_d, sr_q, sr_d;
    logic [XLEN-1:0] or_pc_q, or_pc_d, sr_pc_q, sr_pc_d;
    logic            or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
    logic            accept, consume;

    assign accept  = in_valid && in_ready;
    assign consume = or_valid_q && out_ready;

    // Next state of the OR/SR pair; SR only ever fills while OR is full and stalled.
    always_comb begin
        or_d       = or_q;
        sr_d       = sr_q;
        or_pc_d    = or_pc_q;
        sr_pc_d    = sr_pc_q;
        or_valid_d = or_valid_q;
        sr_valid_d = sr_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (sr_valid_q && consume) begin
            or_d       = sr_q;
            or_pc_d    = sr_pc_q;
            sr_valid_d = 1'b0;
        end else if (accept && (!or_valid_q || consume)) begin
            or_d       = new_entry;
            or_pc_d    = in_pc;
            or_valid_d = 1'b1;
        end else if (accept) begin
            sr_d       = new_entry;
            sr_pc_d    = in_pc;
            sr_valid_d = 1'b1;
        end else if (consume) begin
            or_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_q       <= '0;
            sr_q       <= '0;
            or_pc_q    <= '0;
            sr_pc_q    <= '0;
            or_valid_q <= 1'b0;
            sr_valid_q <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            or_q       <= or_d;
            sr_q       <= sr_d;
            or_pc_q    <= or_pc_d;
            sr_pc_q    <= sr_pc_d;
            or_valid_q <= or_valid_d;
            sr_valid_q <= sr_valid_d;
            in_ready   <= !sr_valid_d;
        end
    end

    assign out_valid   = or_valid_q;
    assign out_instr   = or_q.instr;
    assign out_pc      = or_pc_q;
    assign out_imm     = XLEN'(sext_xlen(or_q.imm, XLEN));
    assign out_fmt     = or_q.fmt;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage at XLEN=32 and XLEN=64 in parallel.
`timescale 1ns/1ps
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] pc64;
    logic        out_ready;

    logic        rdy32, v32, ill32;
    logic [31:0] instr32, pc32, imm32;
    logic [2:0]  fmt32;
    logic        rdy64, v64, ill64;
    logic [31:0] instr64;
    logic [63:0] pco64, imm64;
    logic [2:0]  fmt64;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(pc64[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_instr(instr32), .out_pc(pc32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(pc64),
        .out_valid(v64), .out_ready(out_ready), .out_instr(instr64), .out_pc(pco64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    logic [31:0] dv_instr [11];
    logic [31:0] dv_imm32 [11];
    logic [63:0] dv_imm64 [11];
    logic [2:0]  dv_fmt   [11];
    logic        dv_ill   [11];

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; pc64 = '0; out_ready = 1'b1;
        #12;
        tests++; if (v64 !== 1'b0 || v32 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b want 0", v32, v64); end
        tests++; if (rdy64 !== 1'b1 || rdy32 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b want 1", rdy32, rdy64); end
        tests++; if (instr64 !== 32'h0 || pco64 !== 64'h0 || imm64 !== 64'h0 || fmt64 !== 3'd0 || ill64 !== 1'b0) begin
            errors++; $display("FAIL reset_outputs instr=%h pc=%h imm=%h fmt=%0d ill=%b want all 0", instr64, pco64, imm64, fmt64, ill64);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        dv_instr = '{32'hFFF00093, 32'h7FF00093, 32'hFE112E23, 32'hFE000EE3, 32'h12345137, 32'h80000037,
                     32'hFF9FF06F, 32'h00000033, 32'h0000007F, 32'h00000010, 32'hFFFFF017};
        dv_imm32 = '{32'hFFFFFFFF, 32'h000007FF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
                     32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'hFFFFF000};
        dv_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'h00000000000007FF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                     64'h0000000012345000, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 64'h0,
                     64'hFFFFFFFFFFFFF000};
        dv_fmt   = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd4};
        dv_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_instr = dv_instr[i];
            pc64     = 64'hDEAD000000000000 | 64'(i * 4);
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests++; if (v64 !== 1'b1 || v32 !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d] got %b/%b want 1", i, v32, v64); end
            tests++; if (imm32 !== dv_imm32[i]) begin errors++; $display("FAIL dec_imm32[%0d] got %h want %h", i, imm32, dv_imm32[i]); end
            tests++; if (imm64 !== dv_imm64[i]) begin errors++; $display("FAIL dec_imm64[%0d] got %h want %h", i, imm64, dv_imm64[i]); end
            tests++; if (fmt64 !== dv_fmt[i] || fmt32 !== dv_fmt[i]) begin errors++; $display("FAIL dec_fmt[%0d] got %0d/%0d want %0d", i, fmt32, fmt64, dv_fmt[i]); end
            tests++; if (ill64 !== dv_ill[i] || ill32 !== dv_ill[i]) begin errors++; $display("FAIL dec_illegal[%0d] got %b/%b want %b", i, ill32, ill64, dv_ill[i]); end
            tests++; if (pco64 !== (64'hDEAD000000000000 | 64'(i * 4)) || pc32 !== 32'(i * 4) || instr64 !== dv_instr[i]) begin
                errors++; $display("FAIL dec_pass[%0d] pc=%h/%h instr=%h want pc low %h instr %h", i, pc32, pco64, instr64, 32'(i * 4), dv_instr[i]);
            end
        end
        @(posedge clk); #1;
        tests++; if (v64 !== 1'b0) begin errors++; $display("FAIL dec_drain got %b want 0", v64); end
    endtask

    task automatic test_csr();
        logic [2:0]  efmt;
        logic [63:0] eimm;
`ifdef CSR_IMM_EN
        efmt = 3'd6; eimm = 64'h1F;
`else
        efmt = 3'd1; eimm = 64'h300;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h300FD073;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (fmt64 !== efmt || fmt32 !== efmt) begin errors++; $display("FAIL csr_fmt got %0d/%0d want %0d", fmt32, fmt64, efmt); end
        tests++; if (imm64 !== eimm || imm32 !== eimm[31:0]) begin errors++; $display("FAIL csr_imm got %h/%h want %h", imm32, imm64, eimm); end
        tests++; if (ill64 !== 1'b0) begin errors++; $display("FAIL csr_illegal got %b want 0", ill64); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] bp [6];
        int sent = 0;
        int recv = 0;
        logic acc, cons;
        bp = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093, 32'h00500093, 32'h00600093};
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 6);
            in_instr  = bp[(sent < 6) ? sent : 5];
            pc64      = 64'h1000 + 64'(sent * 4);
            if (cyc == 3 || cyc == 4) begin
                tests++; if (rdy64 !== 1'b0 || rdy32 !== 1'b0) begin errors++; $display("FAIL bp_ready_low c%0d got %b/%b want 0", cyc, rdy32, rdy64); end
                tests++; if (v64 !== 1'b1 || instr64 !== bp[1]) begin errors++; $display("FAIL bp_hold c%0d got v=%b instr=%h want 1 %h", cyc, v64, instr64, bp[1]); end
            end
            if (cyc == 6) begin
                tests++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL bp_ready_high got %b want 1", rdy64); end
            end
            acc  = in_valid && rdy64;
            cons = v64 && out_ready;
            if (cons) begin
                tests++;
                if (recv >= 6) begin
                    errors++; $display("FAIL bp_extra got instr=%h want no more entries", instr64);
                end else if (instr64 !== bp[recv] || pco64 !== 64'h1000 + 64'(recv * 4) || imm64 !== 64'(recv + 1)) begin
                    errors++; $display("FAIL bp_order[%0d] got instr=%h pc=%h imm=%h want %h %h %h", recv, instr64, pco64, imm64,
                                       bp[recv], 64'h1000 + 64'(recv * 4), 64'(recv + 1));
                end
                recv++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        tests++; if (recv != 6 || sent != 6) begin errors++; $display("FAIL bp_count got recv=%0d sent=%0d want 6 6", recv, sent); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0AA00093;
        @(posedge clk); #1;
        in_instr  = 32'h0BB00093;
        @(posedge clk); #1;
        tests++; if (v64 !== 1'b1 || rdy64 !== 1'b0) begin errors++; $display("FAIL flush_setup got v=%b rdy=%b want 1 0", v64, rdy64); end
        in_instr = 32'h0CC00093;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++; if (v64 !== 1'b0 || v32 !== 1'b0) begin errors++; $display("FAIL flush_valid got %b/%b want 0", v32, v64); end
        tests++; if (rdy64 !== 1'b1 || rdy32 !== 1'b1) begin errors++; $display("FAIL flush_ready got %b/%b want 1", rdy32, rdy64); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++; if (v64 !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got v=%b instr=%h want 0", i, v64, instr64); end
        end
        // Flush wins over a simultaneous accept into an empty-SR stage.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0DD00093;
        @(posedge clk); #1;
        in_instr  = 32'h0EE00093;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++; if (v64 !== 1'b0 || rdy64 !== 1'b1) begin errors++; $display("FAIL flush_accept got v=%b rdy=%b want 0 1", v64, rdy64); end
        @(posedge clk); #1;
        tests++; if (v64 !== 1'b0) begin errors++; $display("FAIL flush_accept_ghost got v=%b instr=%h want 0", v64, instr64); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        pc64      = 64'h44;
        @(posedge clk); #1;
        in_instr  = 32'h12345137;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        tests++; if (v64 !== 1'b1 || rdy64 !== 1'b0) begin errors++; $display("FAIL arst_setup got v=%b rdy=%b want 1 0", v64, rdy64); end
        #3 rst = 1'b1;
        #1;
        tests++; if (v64 !== 1'b0 || v32 !== 1'b0) begin errors++; $display("FAIL arst_valid got %b/%b want 0", v32, v64); end
        tests++; if (rdy64 !== 1'b1 || rdy32 !== 1'b1) begin errors++; $display("FAIL arst_ready got %b/%b want 1", rdy32, rdy64); end
        tests++; if (instr64 !== 32'h0 || pco64 !== 64'h0 || imm64 !== 64'h0 || imm32 !== 32'h0 || fmt64 !== 3'd0 || ill64 !== 1'b0) begin
            errors++; $display("FAIL arst_outputs instr=%h pc=%h imm=%h fmt=%0d ill=%b want all 0", instr64, pco64, imm64, fmt64, ill64);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (v64 !== 1'b0) begin errors++; $display("FAIL arst_after got %b want 0", v64); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_csr();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
